// File: rtl/frv_pipeline_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : frv_pipeline_fetch
//  Description : Instruction fetch stage. Issues sequential word-aligned
//                requests to instruction memory (at most one in flight) and
//                buffers the responses in a 2-entry FIFO that feeds decode.
//                The backend redirects fetch with a control flow change
//                request, which flushes buffered words and discards any
//                response still in flight.
//
//  Ports       : g_clk, g_resetn          clock / sync active-low reset
//                cf_req, cf_target        control flow change from backend
//                cf_ack                   control flow change accepted
//                imem_cen, imem_addr      instruction memory request
//                imem_stall               memory holds off acceptance
//                imem_error, imem_rdata   response, one cycle after accept
//                s1_p_valid, s1_p_busy    handshake to decode
//                s1_data, s1_pc, s1_error head FIFO entry presented to decode
//
//  Revision    : 1.0 - initial release
// ============================================================================
module frv_pipeline_fetch #(
    parameter logic [31:0] FRV_PC_RESET_VALUE = 32'h8000_0000
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        cf_req,
    input  logic [31:0] cf_target,
    output logic        cf_ack,
    output logic        imem_cen,
    output logic [31:0] imem_addr,
    input  logic        imem_stall,
    input  logic        imem_error,
    input  logic [31:0] imem_rdata,
    output logic        s1_p_valid,
    input  logic        s1_p_busy,
    output logic [31:0] s1_data,
    output logic [31:0] s1_pc,
    output logic        s1_error
);

    localparam logic [31:0] c_pc_step   = 32'd4;
    localparam logic [31:0] c_word_mask = 32'hFFFF_FFFC;

    // Fetch state
    logic [31:0] r_fetch_pc;   // address of the next request to issue
    logic [31:0] r_resp_pc;    // address of the request currently in flight
    logic        r_in_flight;  // a response arrives this cycle
    logic        r_discard;    // the arriving response belongs to a stale path
    logic        r_hold;       // a request was stalled last cycle and must stay up

    // Response FIFO
    logic [1:0]  r_count;
    logic        r_head;
    logic [31:0] r_fifo_data [0:1];
    logic [31:0] r_fifo_pc   [0:1];
    logic        r_fifo_err  [0:1];

    logic        w_pop;
    logic [1:0]  w_count_after_pop;
    logic        w_room;
    logic        w_accept;
    logic        w_cf_fire;
    logic        w_push;
    logic        w_tail;

    assign w_pop             = (r_count != 2'd0) && !s1_p_busy;
    assign w_count_after_pop = r_count - {1'b0, w_pop};

    // Space is counted against the FIFO as it will be after this cycle's pop,
    // so a continuously draining decode sees one request per cycle.
    assign w_room = (({1'b0, w_count_after_pop} + {2'b0, r_in_flight}) < 3'd2);

    // A stalled request stays asserted regardless of FIFO space or a pending
    // redirect, keeping the address stable until memory accepts it.
    assign imem_cen  = g_resetn && (r_hold || (!cf_req && w_room));
    assign imem_addr = r_fetch_pc;

    assign w_accept  = imem_cen && !imem_stall;

    // The redirect is held off until any stalled request has been accepted.
    assign cf_ack    = g_resetn && cf_req && !(imem_cen && imem_stall);
    assign w_cf_fire = cf_req && cf_ack;

    // Responses on a flushed path are dropped, including one arriving in the
    // very cycle the redirect is acknowledged.
    assign w_push    = r_in_flight && !r_discard && !w_cf_fire;
    assign w_tail    = r_head ^ r_count[0];

    assign s1_p_valid = (r_count != 2'd0);
    assign s1_data    = r_fifo_data[r_head];
    assign s1_pc      = r_fifo_pc[r_head];
    assign s1_error   = r_fifo_err[r_head];

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_fetch_pc  <= FRV_PC_RESET_VALUE;
            r_resp_pc   <= FRV_PC_RESET_VALUE;
            r_in_flight <= 1'b0;
            r_discard   <= 1'b0;
            r_hold      <= 1'b0;
            r_count     <= 2'd0;
            r_head      <= 1'b0;
        end else begin
            r_in_flight <= w_accept;
            r_hold      <= imem_cen && imem_stall;
            // A held request accepted in the redirect cycle is stale.
            r_discard   <= w_cf_fire && w_accept;

            if (w_accept) begin
                r_resp_pc <= r_fetch_pc;
            end

            if (w_cf_fire) begin
                r_fetch_pc <= cf_target & c_word_mask;
                r_count    <= 2'd0;
                r_head     <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + c_pc_step;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + 2'd1;
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - 2'd1;
                end
                if (w_pop) begin
                    r_head <= ~r_head;
                end
            end
        end
    end

    // Entry storage carries no reset; occupancy is tracked by r_count.
    always_ff @(posedge g_clk) begin
        if (w_push) begin
            r_fifo_data[w_tail] <= imem_rdata;
            r_fifo_pc[w_tail]   <= r_resp_pc;
            r_fifo_err[w_tail]  <= imem_error;
        end
    end

endmodule
`default_nettype wire

// File: doc/frv_pipeline_fetch.md
FRV_PIPELINE_FETCH -- requirements
Module: frv_pipeline_fetch

Interface
REQ-001 SHALL have parameter FRV_PC_RESET_VALUE, default 32'h8000_0000, the address of the first fetch after reset.
REQ-002 SHALL have port g_clk, input, 1, the global clock.
REQ-003 SHALL have port g_resetn, input, 1, the reset: synchronous and active-low.
REQ-004 SHALL have port cf_req, input, 1, the control flow change request from the backend.
REQ-005 SHALL have port cf_target, input, 32, the control flow change target.
REQ-006 SHALL have port cf_ack, output, 1, the control flow change acknowledge.
REQ-007 SHALL have port imem_cen, output, 1, the instruction memory request enable.
REQ-008 SHALL have port imem_addr, output, 32, the word-aligned fetch address.
REQ-009 SHALL have port imem_stall, input, 1, which holds off acceptance of the current request.
REQ-010 SHALL have port imem_error, input, 1, the response error, valid 1 cycle after acceptance.
REQ-011 SHALL have port imem_rdata, input, 32, the response data, valid 1 cycle after acceptance.
REQ-012 SHALL have port s1_p_valid, output, 1, which marks the fetched word as valid to decode.
REQ-013 SHALL have port s1_p_busy, input, 1, which marks decode as unable to accept this cycle.
REQ-014 SHALL have port s1_data, output, 32, the fetched instruction word.
REQ-015 SHALL have port s1_pc, output, 32, the address of s1_data.
REQ-016 SHALL have port s1_error, output, 1, which marks the word as fetched with a bus error.

Function
REQ-017 SHALL accept an imem request in a cycle with imem_cen=1 and imem_stall=0; the response SHALL be sampled the following cycle, and at most 1 request SHALL be in flight.
REQ-018 SHALL keep imem_cen and imem_addr stable while imem_cen=1 and imem_stall=1.
REQ-019 SHALL hold a 2-entry FIFO of {data, pc, error}; s1_data, s1_pc and s1_error SHALL present the head entry.
REQ-020 SHALL set s1_p_valid = (FIFO count != 0); an entry SHALL pop on s1_p_valid && !s1_p_busy.
REQ-021 SHALL assert imem_cen only when count + in_flight < 2 and no cf_req is pending.
REQ-022 SHALL add 4 to fetch_pc on each accepted request, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-023 SHALL write a non-discarded response into the FIFO tail; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-024 SHALL drive cf_ack = cf_req && !(imem_cen && imem_stall), so the ack waits for a stalled request to be accepted.
REQ-025 On cf_req && cf_ack, the block SHALL:
- empty the FIFO;
- mark any in-flight response as discarded;
- load fetch_pc <= {cf_target[31:2], 2'b00}.
REQ-026 SHALL NOT issue a new request in the cf_ack cycle; the first request to the target SHALL be issued the next cycle.
REQ-027 SHALL drop a discarded response, with no FIFO write and no s1_error.
REQ-028 SHALL store imem_error=1 with its entry and SHALL keep fetching sequentially; trap handling belongs downstream.
REQ-029 Latency: request issued in cycle N, response in N+1, s1_p_valid in N+2 (no bypass).
REQ-030 When the FIFO is full and s1_p_busy=1, the block SHALL issue no request and SHALL hold all outputs.

Reset
REQ-031 While g_resetn=0 on a clock edge, the block SHALL reset:
- fetch_pc <= FRV_PC_RESET_VALUE;
- FIFO count <= 0;
- in_flight <= 0;
- discard <= 0.
REQ-032 Outputs in reset SHALL be s1_p_valid=0, imem_cen=0 and cf_ack=0; a reset mid-operation SHALL drop the in-flight response and all buffered entries.
REQ-033 The first request after reset release SHALL be imem_cen=1 with imem_addr=FRV_PC_RESET_VALUE, in the first cycle with g_resetn=1.

Verification
REQ-034 Reset release, imem_stall=0, s1_p_busy=0 -> imem_addr sequence 8000_0000, 8000_0004, ... one per cycle once streaming; s1_p_valid first high 2 cycles after the first request, with s1_pc=8000_0000.
REQ-035 s1_p_busy=1 for 10 cycles -> exactly 2 entries buffered and imem_cen=0 thereafter; release busy -> entries pop in order 8000_0000, 8000_0004 with no loss or duplication.
REQ-036 cf_req with cf_target=0000_0102 while a response is in flight -> cf_ack the same cycle; the in-flight word is never presented; next imem_addr=0000_0100.
REQ-037 cf_req while imem_cen=1 and imem_stall=1 for 3 cycles -> cf_ack low until the stall drops; the accepted response is discarded; the FIFO is empty in the cycle after cf_ack.
REQ-038 imem_error=1 on the response for 8000_0008 -> that entry has s1_error=1; the next entry (8000_000C) has s1_error=0.
REQ-039 fetch_pc=FFFF_FFFC -> the next request address is 0000_0000; g_resetn=0 mid-stream -> s1_p_valid=0 and imem_cen=0 the next cycle.
